// File: rtl/cci_mpf_svc_vtp_tlb_fa.sv
// Fully associative VTP TLB serving two lookup channels and one fill port.
//
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   lookupPageVA/En[c]   - per-channel lookup request (4KB VA page index)
//   lookupRdy[c]         - channel ready; requests are never back-pressured
//   lookupValid/Miss[c]  - hit / miss strobe, 2 cycles after the request
//   lookupRspPagePA[c]   - translated 4KB PA page index (held on a miss)
//   lookupIsBigPage[c]   - hit entry is a 2MB page
//   lookupMissVA[c]      - VA that missed
//   fillEn/VA/PA/BigPage - fill request from the page table walker
//   fillRdy              - fill accepted when fillEn && fillRdy
//
// Optional build macro MPF_VTP_TLB_STATS_EN adds saturating statistics outputs
// statHits[c], statMisses[c] and statFills.
module cci_mpf_svc_vtp_tlb_fa #(
  parameter int unsigned NUM_ENTRIES = 32,
  parameter int unsigned VA_IDX_BITS = 36,
  parameter int unsigned PA_IDX_BITS = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [VA_IDX_BITS-1:0] lookupPageVA    [0:1],
  input  logic                   lookupEn        [0:1],
  output logic                   lookupRdy       [0:1],
  output logic [PA_IDX_BITS-1:0] lookupRspPagePA [0:1],
  output logic                   lookupIsBigPage [0:1],
  output logic                   lookupValid     [0:1],
  output logic                   lookupMiss      [0:1],
  output logic [VA_IDX_BITS-1:0] lookupMissVA    [0:1],
  input  logic                   fillEn,
  input  logic [VA_IDX_BITS-1:0] fillVA,
  input  logic [PA_IDX_BITS-1:0] fillPA,
  input  logic                   fillBigPage,
  output logic                   fillRdy
`ifdef MPF_VTP_TLB_STATS_EN
  ,
  output logic [31:0]            statHits        [0:1],
  output logic [31:0]            statMisses      [0:1],
  output logic [31:0]            statFills
`endif
);

  // A 2MB page covers 512 4KB pages.
  localparam int unsigned BigBits = 9;
  localparam int unsigned IdxW    = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  // Coarse compare ignores the 4KB offset within a 2MB page.
  function automatic logic va_match(input logic [VA_IDX_BITS-1:0] a,
                                    input logic [VA_IDX_BITS-1:0] b,
                                    input logic                   coarse);
    if (coarse) return a[VA_IDX_BITS-1:BigBits] == b[VA_IDX_BITS-1:BigBits];
    return a == b;
  endfunction

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  logic [NUM_ENTRIES-1:0] ent_valid_q, ent_valid_d;
  logic [NUM_ENTRIES-1:0] ent_big_q, ent_big_d;
  logic [VA_IDX_BITS-1:0] ent_va_q [NUM_ENTRIES];
  logic [VA_IDX_BITS-1:0] ent_va_d [NUM_ENTRIES];
  logic [PA_IDX_BITS-1:0] ent_pa_q [NUM_ENTRIES];
  logic [PA_IDX_BITS-1:0] ent_pa_d [NUM_ENTRIES];
  logic [IdxW-1:0]        victim_q, victim_d;

  // ---------------------------------------------------------------------------
  // Fill FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {StIdle, StWrite} fill_state_e;

  fill_state_e            state_q, state_d;
  logic                   fill_rdy_q, fill_rdy_d;
  logic [VA_IDX_BITS-1:0] fill_va_q, fill_va_d;
  logic [PA_IDX_BITS-1:0] fill_pa_q, fill_pa_d;
  logic                   fill_big_q, fill_big_d;
  logic                   fill_wr;

  always_comb begin
    state_d    = state_q;
    fill_rdy_d = fill_rdy_q;
    fill_va_d  = fill_va_q;
    fill_pa_d  = fill_pa_q;
    fill_big_d = fill_big_q;
    fill_wr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fillEn) begin
          // Store big-page VAs pre-masked so the tag compare is uniform.
          fill_va_d  = fillBigPage ? {fillVA[VA_IDX_BITS-1:BigBits], {BigBits{1'b0}}} : fillVA;
          fill_pa_d  = fillPA;
          fill_big_d = fillBigPage;
          fill_rdy_d = 1'b0;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        fill_wr    = 1'b1;
        fill_rdy_d = 1'b1;
        state_d    = StIdle;
      end
      default: begin
        fill_rdy_d = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      fill_rdy_q <= 1'b1;
      fill_va_q  <= '0;
      fill_pa_q  <= '0;
      fill_big_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_rdy_q <= fill_rdy_d;
      fill_va_q  <= fill_va_d;
      fill_pa_q  <= fill_pa_d;
      fill_big_q <= fill_big_d;
    end
  end

  assign fillRdy = fill_rdy_q;

  // ---------------------------------------------------------------------------
  // Fill target selection: duplicate, else lowest invalid, else victim
  // ---------------------------------------------------------------------------
  logic            dup_hit, inv_hit;
  logic [IdxW-1:0] dup_idx, inv_idx, tgt_idx;

  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
    inv_hit = 1'b0;
    inv_idx = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (ent_valid_q[i] && va_match(ent_va_q[i], fill_va_q, ent_big_q[i] | fill_big_q)) begin
        dup_hit = 1'b1;
        dup_idx = IdxW'(i);
      end
      if (!ent_valid_q[i]) begin
        inv_hit = 1'b1;
        inv_idx = IdxW'(i);
      end
    end
  end

  always_comb begin
    ent_valid_d = ent_valid_q;
    ent_big_d   = ent_big_q;
    ent_va_d    = ent_va_q;
    ent_pa_d    = ent_pa_q;
    victim_d    = victim_q;
    tgt_idx     = dup_hit ? dup_idx : (inv_hit ? inv_idx : victim_q);
    if (fill_wr) begin
      ent_valid_d[tgt_idx] = 1'b1;
      ent_big_d[tgt_idx]   = fill_big_q;
      ent_va_d[tgt_idx]    = fill_va_q;
      ent_pa_d[tgt_idx]    = fill_pa_q;
      // Power-of-2 depth makes the wrap implicit.
      if (!dup_hit && !inv_hit) victim_d = victim_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid_q <= '0;
      ent_big_q   <= '0;
      victim_q    <= '0;
    end else begin
      ent_valid_q <= ent_valid_d;
      ent_big_q   <= ent_big_d;
      victim_q    <= victim_d;
    end
  end

  // Payload needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    ent_va_q <= ent_va_d;
    ent_pa_q <= ent_pa_d;
  end

  // ---------------------------------------------------------------------------
  // Lookup pipeline: request register, then compare + response register
  // ---------------------------------------------------------------------------
  logic [1:0]             la_en_q, la_en_d;
  logic [VA_IDX_BITS-1:0] la_va_q [2];
  logic [VA_IDX_BITS-1:0] la_va_d [2];

  logic [1:0]             hit_or, big_or;
  logic [PA_IDX_BITS-1:0] pa_or [2];

  logic [1:0]             rsp_valid_q, rsp_valid_d;
  logic [1:0]             rsp_miss_q, rsp_miss_d;
  logic [1:0]             rsp_big_q, rsp_big_d;
  logic [PA_IDX_BITS-1:0] rsp_pa_q [2];
  logic [PA_IDX_BITS-1:0] rsp_pa_d [2];
  logic [VA_IDX_BITS-1:0] miss_va_q [2];
  logic [VA_IDX_BITS-1:0] miss_va_d [2];

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      la_en_d[c] = lookupEn[c];
      la_va_d[c] = lookupPageVA[c];
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      hit_or[c] = 1'b0;
      big_or[c] = 1'b0;
      pa_or[c]  = '0;
      // At most one entry matches, so OR-ing the selected entries is the mux.
      for (int e = 0; e < int'(NUM_ENTRIES); e++) begin
        if (ent_valid_q[e] && va_match(ent_va_q[e], la_va_q[c], ent_big_q[e])) begin
          hit_or[c] = 1'b1;
          big_or[c] = big_or[c] | ent_big_q[e];
          pa_or[c]  = pa_or[c] | ent_pa_q[e];
        end
      end

      rsp_valid_d[c] = la_en_q[c] & hit_or[c];
      rsp_miss_d[c]  = la_en_q[c] & ~hit_or[c];
      rsp_big_d[c]   = la_en_q[c] & hit_or[c] & big_or[c];

      rsp_pa_d[c] = rsp_pa_q[c];
      if (rsp_valid_d[c]) begin
        rsp_pa_d[c] = big_or[c] ? {pa_or[c][PA_IDX_BITS-1:BigBits], la_va_q[c][BigBits-1:0]}
                                : pa_or[c];
      end

      miss_va_d[c] = miss_va_q[c];
      if (rsp_miss_d[c]) miss_va_d[c] = la_va_q[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      la_en_q     <= '0;
      rsp_valid_q <= '0;
      rsp_miss_q  <= '0;
      rsp_big_q   <= '0;
      for (int c = 0; c < 2; c++) begin
        la_va_q[c]   <= '0;
        rsp_pa_q[c]  <= '0;
        miss_va_q[c] <= '0;
      end
    end else begin
      la_en_q     <= la_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_miss_q  <= rsp_miss_d;
      rsp_big_q   <= rsp_big_d;
      for (int c = 0; c < 2; c++) begin
        la_va_q[c]   <= la_va_d[c];
        rsp_pa_q[c]  <= rsp_pa_d[c];
        miss_va_q[c] <= miss_va_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      lookupRdy[c]       = ~reset;
      lookupValid[c]     = rsp_valid_q[c];
      lookupMiss[c]      = rsp_miss_q[c];
      lookupIsBigPage[c] = rsp_big_q[c];
      lookupRspPagePA[c] = rsp_pa_q[c];
      lookupMissVA[c]    = miss_va_q[c];
    end
  end

`ifdef MPF_VTP_TLB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  logic [31:0] hits_q [2];
  logic [31:0] hits_d [2];
  logic [31:0] misses_q [2];
  logic [31:0] misses_d [2];
  logic [31:0] fills_q, fills_d;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      hits_d[c]   = hits_q[c];
      misses_d[c] = misses_q[c];
      if (rsp_valid_q[c] && (hits_q[c] != '1)) hits_d[c] = hits_q[c] + 32'd1;
      if (rsp_miss_q[c] && (misses_q[c] != '1)) misses_d[c] = misses_q[c] + 32'd1;
    end
    fills_d = fills_q;
    if (fill_wr && (fills_q != '1)) fills_d = fills_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fills_q <= '0;
      for (int c = 0; c < 2; c++) begin
        hits_q[c]   <= '0;
        misses_q[c] <= '0;
      end
    end else begin
      fills_q <= fills_d;
      for (int c = 0; c < 2; c++) begin
        hits_q[c]   <= hits_d[c];
        misses_q[c] <= misses_d[c];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      statHits[c]   = hits_q[c];
      statMisses[c] = misses_q[c];
    end
    statFills = fills_q;
  end
`endif

endmodule

// File: tb/tb_cci_mpf_svc_vtp_tlb_fa.sv
`timescale 1ns/1ps
module tb_cci_mpf_svc_vtp_tlb_fa;
  localparam int N = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [35:0] lookupPageVA    [0:1];
  logic        lookupEn        [0:1];
  logic        lookupRdy       [0:1];
  logic [25:0] lookupRspPagePA [0:1];
  logic        lookupIsBigPage [0:1];
  logic        lookupValid     [0:1];
  logic        lookupMiss      [0:1];
  logic [35:0] lookupMissVA    [0:1];
  logic        fillEn;
  logic [35:0] fillVA;
  logic [25:0] fillPA;
  logic        fillBigPage;
  logic        fillRdy;
`ifdef MPF_VTP_TLB_STATS_EN
  logic [31:0] statHits   [0:1];
  logic [31:0] statMisses [0:1];
  logic [31:0] statFills;
`endif

  always #5 clk = ~clk;

  cci_mpf_svc_vtp_tlb_fa #(
    .NUM_ENTRIES(N),
    .VA_IDX_BITS(36),
    .PA_IDX_BITS(26)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .lookupPageVA   (lookupPageVA),
    .lookupEn       (lookupEn),
    .lookupRdy      (lookupRdy),
    .lookupRspPagePA(lookupRspPagePA),
    .lookupIsBigPage(lookupIsBigPage),
    .lookupValid    (lookupValid),
    .lookupMiss     (lookupMiss),
    .lookupMissVA   (lookupMissVA),
    .fillEn         (fillEn),
    .fillVA         (fillVA),
    .fillPA         (fillPA),
    .fillBigPage    (fillBigPage),
    .fillRdy        (fillRdy)
`ifdef MPF_VTP_TLB_STATS_EN
    ,
    .statHits       (statHits),
    .statMisses     (statMisses),
    .statFills      (statFills)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected response of one lookup.
  typedef struct packed {
    logic        en;
    logic        hit;
    logic [25:0] pa;
    logic        big;
    logic [35:0] va;
  } exp_t;

  exp_t cur [2];  // response visible this cycle
  exp_t nxt [2];  // response visible next cycle

  // Reference TLB contents.
  bit          m_valid [N];
  logic [35:0] m_va    [N];
  logic [25:0] m_pa    [N];
  bit          m_big   [N];
  int          m_victim;
  bit          m_pend;
  logic [35:0] p_va;
  logic [25:0] p_pa;
  bit          p_big;
  int          m_hits [2];
  int          m_misses [2];
  int          m_fills;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int e = 0; e < N; e++) m_valid[e] = 1'b0;
    m_victim = 0;
    m_pend   = 1'b0;
    m_fills  = 0;
    for (int c = 0; c < 2; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      m_hits[c] = 0;
      m_misses[c] = 0;
    end
  endtask

  function automatic exp_t m_lookup(input logic en, input logic [35:0] v);
    exp_t r;
    r = '0;
    r.en = en;
    r.va = v;
    for (int e = 0; e < N; e++) begin
      if (m_valid[e] && (m_big[e] ? (m_va[e][35:9] == v[35:9]) : (m_va[e] == v))) begin
        r.hit = 1'b1;
        r.big = m_big[e];
        r.pa  = m_big[e] ? {m_pa[e][25:9], v[8:0]} : m_pa[e];
      end
    end
    return r;
  endfunction

  task automatic m_write();
    int tgt;
    logic [35:0] wva;
    tgt = -1;
    wva = p_big ? {p_va[35:9], 9'h0} : p_va;
    for (int e = 0; e < N; e++)
      if (tgt < 0 && m_valid[e] &&
          ((m_big[e] || p_big) ? (m_va[e][35:9] == wva[35:9]) : (m_va[e] == wva)))
        tgt = e;
    for (int e = 0; e < N; e++)
      if (tgt < 0 && !m_valid[e]) tgt = e;
    if (tgt < 0) begin
      tgt = m_victim;
      m_victim = (m_victim + 1) % N;
    end
    m_valid[tgt] = 1'b1;
    m_va[tgt]    = wva;
    m_pa[tgt]    = p_pa;
    m_big[tgt]   = p_big;
    m_fills++;
  endtask

  // Advance the model by one clock using the inputs the bench drove this cycle.
  task automatic model_update();
    for (int c = 0; c < 2; c++)
      if (cur[c].en) begin
        if (cur[c].hit) m_hits[c]++;
        else m_misses[c]++;
      end
    cur = nxt;
    if (m_pend) begin
      m_write();
      m_pend = 1'b0;
    end else if (fillEn) begin
      m_pend = 1'b1;
      p_va = fillVA;
      p_pa = fillPA;
      p_big = fillBigPage;
    end
    for (int c = 0; c < 2; c++) nxt[c] = m_lookup(lookupEn[c], lookupPageVA[c]);
  endtask

  task automatic compare();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("rdy%0d", c), 64'(lookupRdy[c]), 64'd1);
      chk($sformatf("valid%0d", c), 64'(lookupValid[c]), 64'(cur[c].en && cur[c].hit));
      chk($sformatf("miss%0d", c), 64'(lookupMiss[c]), 64'(cur[c].en && !cur[c].hit));
      if (cur[c].en && cur[c].hit) begin
        chk($sformatf("pa%0d", c), 64'(lookupRspPagePA[c]), 64'(cur[c].pa));
        chk($sformatf("big%0d", c), 64'(lookupIsBigPage[c]), 64'(cur[c].big));
      end
      if (cur[c].en && !cur[c].hit)
        chk($sformatf("missva%0d", c), 64'(lookupMissVA[c]), 64'(cur[c].va));
`ifdef MPF_VTP_TLB_STATS_EN
      chk($sformatf("stat_hits%0d", c), 64'(statHits[c]), 64'(m_hits[c]));
      chk($sformatf("stat_misses%0d", c), 64'(statMisses[c]), 64'(m_misses[c]));
`endif
    end
    chk("fill_rdy", 64'(fillRdy), 64'(!m_pend));
`ifdef MPF_VTP_TLB_STATS_EN
    chk("stat_fills", 64'(statFills), 64'(m_fills));
`endif
  endtask

  task automatic cyc(input logic e0, input logic [35:0] v0, input logic e1, input logic [35:0] v1,
                     input logic fe, input logic [35:0] fva, input logic [25:0] fpa,
                     input logic fb);
    @(negedge clk);
    compare();
    lookupEn[0] = e0;
    lookupPageVA[0] = v0;
    lookupEn[1] = e1;
    lookupPageVA[1] = v1;
    fillEn = fe;
    fillVA = fva;
    fillPA = fpa;
    fillBigPage = fb;
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Reset asserted mid-cycle, dropping any in-flight lookup or fill.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      lookupEn[c] = 1'b0;
      lookupPageVA[c] = '0;
    end
    fillEn = 1'b0;
    fillVA = '0;
    fillPA = '0;
    fillBigPage = 1'b0;
    m_clear();
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_valid", 64'(lookupValid[c]), 64'd0);
      chk("rst_miss", 64'(lookupMiss[c]), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_fill_rdy", 64'(fillRdy), 64'd1);
    chk("post_rst_lookup_rdy", 64'(lookupRdy[0]), 64'd1);
`ifdef MPF_VTP_TLB_STATS_EN
    chk("post_rst_stat_hits", 64'(statHits[0]), 64'd0);
    chk("post_rst_stat_misses", 64'(statMisses[1]), 64'd0);
    chk("post_rst_stat_fills", 64'(statFills), 64'd0);
`endif
    @(posedge clk);
    model_update();
  endtask

  function automatic logic [35:0] rnd_small();
    return {27'($urandom_range(0, 3)), 9'($urandom_range(0, 15))};
  endfunction

  function automatic logic [35:0] rnd_big();
    return {27'($urandom_range(4, 5)), 9'($urandom_range(0, 511))};
  endfunction

  function automatic logic [35:0] rnd_lookup();
    if ($urandom_range(0, 3) == 0) return rnd_big();
    return rnd_small();
  endfunction

  initial begin
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      lookupEn[c] = 1'b0;
      lookupPageVA[c] = '0;
    end
    fillEn = 1'b0;
    fillVA = '0;
    fillPA = '0;
    fillBigPage = 1'b0;
    m_clear();
    do_reset();

    // Cold miss.
    cyc(1'b1, 36'h000012345, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    idle(1);
    #1;
    chk("cold_miss", 64'(lookupMiss[0]), 64'd1);
    chk("cold_missva", 64'(lookupMissVA[0]), 64'h000012345);
    chk("cold_valid", 64'(lookupValid[0]), 64'd0);

    // 4KB fill; lookup in the accept cycle misses, the next one hits.
    cyc(1'b1, 36'h000012345, 1'b0, '0, 1'b1, 36'h000012345, 26'h0ABCDE, 1'b0);
    cyc(1'b1, 36'h000012345, 1'b0, '0, 1'b0, '0, '0, 1'b0);
    #1;
    chk("fill_f_miss", 64'(lookupMiss[0]), 64'd1);
    idle(1);
    #1;
    chk("fill_f1_valid", 64'(lookupValid[0]), 64'd1);
    chk("fill_f1_pa", 64'(lookupRspPagePA[0]), 64'h0ABCDE);
    chk("fill_f1_big", 64'(lookupIsBigPage[0]), 64'd0);

    // 2MB fill, both channels hit the same entry.
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 36'h000400000, 26'h0200000, 1'b1);
    idle(1);
    cyc(1'b1, 36'h0004001FF, 1'b1, 36'h000400005, 1'b0, '0, '0, 1'b0);
    idle(1);
    #1;
    chk("big_pa0", 64'(lookupRspPagePA[0]), 64'h02001FF);
    chk("big_pa1", 64'(lookupRspPagePA[1]), 64'h0200005);
    chk("big_flag0", 64'(lookupIsBigPage[0]), 64'd1);
    chk("big_flag1", 64'(lookupIsBigPage[1]), 64'd1);

    // Duplicate fill overwrites in place; 31 more fills still fit.
    do_reset();
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 36'h000000100, 26'h000111, 1'b0);
    idle(1);
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 36'h000000100, 26'h000222, 1'b0);
    idle(1);
    for (int i = 0; i < N - 1; i++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 36'h000001000 + 36'(i), 26'(i), 1'b0);
      idle(1);
    end
    cyc(1'b1, 36'h000000100, 1'b1, 36'h000001000, 1'b0, '0, '0, 1'b0);
    idle(1);
    #1;
    chk("dup_valid", 64'(lookupValid[0]), 64'd1);
    chk("dup_pa", 64'(lookupRspPagePA[0]), 64'h000222);
    chk("dup_first_kept", 64'(lookupValid[1]), 64'd1);
    for (int i = 0; i < N - 1; i += 2)
      cyc(1'b1, 36'h000001000 + 36'(i), 1'b1, 36'h000001001 + 36'(i), 1'b0, '0, '0, 1'b0);
    idle(2);

    // N+1 back-to-back fills evict entry 0.
    do_reset();
    for (int i = 0; i <= N; i++) begin
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 36'(i), 26'h1000 + 26'(i), 1'b0);
      #1;
      chk("b2b_rdy_low", 64'(fillRdy), 64'd0);
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 36'(i), 26'h1000 + 26'(i), 1'b0);
      #1;
      chk("b2b_rdy_high", 64'(fillRdy), 64'd1);
    end
    cyc(1'b1, 36'd0, 1'b1, 36'd32, 1'b0, '0, '0, 1'b0);
    idle(1);
    #1;
    chk("evict_miss0", 64'(lookupMiss[0]), 64'd1);
    chk("evict_hit32", 64'(lookupValid[1]), 64'd1);
    chk("evict_pa32", 64'(lookupRspPagePA[1]), 64'h1020);
    for (int i = 1; i <= N; i += 2)
      cyc(1'b1, 36'(i), 1'b1, 36'(i + 1), 1'b0, '0, '0, 1'b0);
    idle(2);

    // Reset during the write cycle with lookups in flight.
    cyc(1'b0, '0, 1'b0, '0, 1'b1, 36'h5, 26'h55, 1'b0);
    idle(1);
    cyc(1'b1, 36'h5, 1'b1, 36'h6, 1'b1, 36'h7, 26'h77, 1'b0);
    do_reset();
    cyc(1'b1, 36'h7, 1'b1, 36'h5, 1'b0, '0, '0, 1'b0);
    idle(1);
    #1;
    chk("rst_drop_miss7", 64'(lookupMiss[0]), 64'd1);
    chk("rst_drop_miss5", 64'(lookupMiss[1]), 64'd1);
    idle(1);

    // Randomized traffic; 4KB and 2MB fills use disjoint regions.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      logic        fb;
      logic [35:0] fva;
      if (k % 1000 == 999) do_reset();
      fb  = ($urandom_range(0, 3) == 0);
      fva = fb ? rnd_big() : rnd_small();
      cyc(1'($urandom_range(0, 3) != 0), rnd_lookup(),
          1'($urandom_range(0, 3) != 0), rnd_lookup(),
          1'($urandom_range(0, 2) == 0), fva, 26'($urandom), fb);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cci_mpf_svc_vtp_tlb_fa.md
Name: cci_mpf_svc_vtp_tlb_fa

Overview:
- Server end of the VTP TLB lookup/fill interface: a fully associative TLB holding mixed 4KB and 2MB translations.
- Serves two independent lookup channels with a fixed 2-cycle response.
- Reports misses with the missing VA and accepts fills from the page table walker.
- All addresses are 4KB-normalized line page indices: VA 36 bits, PA 26 bits.

Parameters:
NUM_ENTRIES, 32, number of TLB entries; power of 2, >= 2
VA_IDX_BITS, 36, 4KB VA page index width (42-6)
PA_IDX_BITS, 26, 4KB PA page index width (32-6)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
lookupPageVA[0:1]  input  2x36  VA page index per channel
lookupEn[0:1]  input  2x1  lookup request per channel
lookupRdy[0:1]  output  2x1  channel ready
lookupRspPagePA[0:1]  output  2x26  translated 4KB PA page index
lookupIsBigPage[0:1]  output  2x1  hit entry is a 2MB page
lookupValid[0:1]  output  2x1  hit response
lookupMiss[0:1]  output  2x1  miss response
lookupMissVA[0:1]  output  2x36  VA that missed
fillEn  input  1  fill request
fillVA  input  36  fill VA page index
fillPA  input  26  fill PA page index
fillBigPage  input  1  1 = 2MB page, 0 = 4KB page
fillRdy  output  1  fill accepted when fillEn && fillRdy

Behaviour:
- Reset (async, active-high): all entry valid bits 0; all outputs 0 except lookupRdy and fillRdy; victim pointer 0; fill FSM IDLE. Assertion mid-operation drops in-flight lookups and fills; no response is produced for them.
- lookupRdy[c] = !reset. Requests are accepted every cycle; no backpressure.
- Lookup pipeline, request in cycle T:
  - T: VA and enable registered.
  - T+1: tag compare against the array contents of cycle T+1; hit vector registered.
  - T+2: exactly one of lookupValid/lookupMiss is asserted for one cycle; both are 0 when lookupEn was 0.
  - Channels are fully independent; both may hit the same entry in the same cycle.
- Match rule (entry e, lookup VA v):
  - e.big: e.va[35:9] == v[35:9].
  - !e.big: e.va == v.
- Hit response:
  - lookupRspPagePA = e.big ? {e.pa[25:9], v[8:0]} : e.pa.
  - lookupIsBigPage = e.big.
- Miss response: lookupMissVA = v. lookupRspPagePA is don't-care; drive the last value.
- Fill FSM:
  - IDLE: fillRdy=1. On fillEn, latch VA/PA/big and go to WRITE.
  - WRITE: fillRdy=0. Search for a duplicate: a valid entry with equal VA under the coarser mask (bits [35:9] if either side is big). Select the target entry:
    - duplicate present: the duplicate (overwritten);
    - else lowest-indexed invalid entry;
    - else the victim pointer, which then increments modulo NUM_ENTRIES.
  - Write the entry (store VA with low 9 bits zeroed when big) and return to IDLE.
  - Maximum fill rate: 1 per 2 cycles.
- Fill/lookup ordering:
  - A fill accepted in cycle F is written at the end of F+1.
  - Lookups with T >= F+1 see it; lookups with T <= F do not.
- The duplicate rule guarantees at most one hit per lookup; the PA mux is an OR-reduction of one-hot selected entries.
- No invalidation; entries leave only by replacement or reset.

Optional Feature:
- Macro: MPF_VTP_TLB_STATS_EN.
- When defined:
  - Adds outputs statHits[0:1], statMisses[0:1] (2x32 each) and statFills (32).
  - Counters increment on lookupValid, lookupMiss and fill write respectively, saturate at 2^32-1, and reset to 0.
- When undefined: the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- After reset, lookup ch0 VA 0x000012345 -> cycle T+2: lookupMiss[0]=1, lookupMissVA[0]=0x000012345, lookupValid[0]=0.
- Fill 4KB VA 0x000012345 -> PA 0x0ABCDE; lookup at F+1 -> lookupValid=1, PA 0x0ABCDE, lookupIsBigPage=0. Lookup at F -> miss.
- Fill 2MB VA 0x000400000 -> PA 0x0200000; ch0 VA 0x0004001FF and ch1 VA 0x000400005 in the same cycle -> PA 0x02001FF and 0x0200005, both IsBigPage=1.
- Fill VA 0x000000100 with PA 0x000111, then the same VA with PA 0x000222 -> lookup returns 0x000222. Fill count 2, yet only 1 entry is used: a further NUM_ENTRIES-1 distinct fills cause no eviction.
- Fill NUM_ENTRIES+1 distinct 4KB VAs 0..32 -> VA 0 (entry 0) evicted and misses; VAs 1..32 hit. fillRdy toggles 1,0 on back-to-back fillEn.
- Assert reset during a fill WRITE cycle and with lookups in flight -> no lookupValid/lookupMiss afterwards, all entries miss, fillRdy=1 on the first cycle after deassertion. With MPF_VTP_TLB_STATS_EN defined, the counters read 0.
